// File: rtl/capture_pkg.sv
// capture_pkg -- shared definitions for the capture write controller.
//   CAP_ADDR_W / CAP_DATA_W / CAP_DEPTH : capture RAM geometry (8192 x 11)
//   CAP_CNT_W                           : width of sample counters (holds 8192)
//   cap_state_e                         : capture state machine encoding
//   eff_post_count()                    : post-trigger sample count actually
//                                         retained, clipped to the free RAM space
package capture_pkg;

  localparam int unsigned CAP_ADDR_W = 13;
  localparam int unsigned CAP_DATA_W = 11;
  localparam int unsigned CAP_DEPTH  = 8192;
  localparam int unsigned CAP_CNT_W  = 14;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WAIT_TRIG,
    POST,
    DONE
  } cap_state_e;

  // max(1, min(post, DEPTH - pre)): the post window may never overwrite the
  // pre-trigger history, and always keeps at least the trigger sample.
  function automatic logic [CAP_CNT_W-1:0] eff_post_count(
    input logic [CAP_ADDR_W-1:0] pre,
    input logic [CAP_CNT_W-1:0]  post
  );
    logic [CAP_CNT_W-1:0] room;
    logic [CAP_CNT_W-1:0] m;
    room = CAP_CNT_W'(CAP_DEPTH) - {1'b0, pre};
    m    = (post < room) ? post : room;
    return (m == '0) ? CAP_CNT_W'(1) : m;
  endfunction

endpackage

// File: rtl/capture_trig_det.sv
// capture_trig_det -- edge trigger detector with optional hysteresis.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clear    : capture restart; forgets the previous sample
//   i_valid    : a sample is being accepted this cycle
//   i_eval     : trigger evaluation enabled (only waiting-for-trigger)
//   i_data     : current sample
//   i_level    : threshold
//   i_edge     : 0 = rising, 1 = falling
//   i_hyst     : hysteresis band (only with CAPTURE_TRIG_HYST_EN)
//   o_trig     : trigger condition for the current sample
// Optional feature macro: CAPTURE_TRIG_HYST_EN.
module capture_trig_det
  import capture_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic                  i_valid,
  input  logic                  i_eval,
  input  logic [CAP_DATA_W-1:0] i_data,
  input  logic [CAP_DATA_W-1:0] i_level,
  input  logic                  i_edge,
`ifdef CAPTURE_TRIG_HYST_EN
  input  logic [4:0]            i_hyst,
`endif
  output logic                  o_trig
);

  logic [CAP_DATA_W-1:0] r_prev;
  logic                  r_prev_vld;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_cond;

  always_comb begin
    w_rise = r_prev_vld && (r_prev <  i_level) && (i_data >= i_level);
    w_fall = r_prev_vld && (r_prev >= i_level) && (i_data <  i_level);
    w_cond = i_eval && (i_edge ? w_fall : w_rise);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
    end else if (i_clear) begin
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
    end else if (i_valid) begin
      r_prev     <= i_data;
      r_prev_vld <= 1'b1;
    end
  end

`ifdef CAPTURE_TRIG_HYST_EN
  // Once fired, the detector stays disarmed until the signal has left the
  // band on the far side of the level. The armed flag survives a capture
  // restart so a noisy signal cannot re-fire just because of a new arm.
  logic                  r_armed;
  logic [CAP_DATA_W-1:0] w_hyst_ext;
  logic [CAP_DATA_W:0]   w_hi_sum;
  logic [CAP_DATA_W-1:0] w_lo;
  logic [CAP_DATA_W-1:0] w_hi;
  logic                  w_rearm;

  always_comb begin
    w_hyst_ext = {{(CAP_DATA_W-5){1'b0}}, i_hyst};
    w_lo       = (i_level > w_hyst_ext) ? (i_level - w_hyst_ext) : '0;
    w_hi_sum   = {1'b0, i_level} + {1'b0, w_hyst_ext};
    w_hi       = w_hi_sum[CAP_DATA_W] ? '1 : w_hi_sum[CAP_DATA_W-1:0];
    w_rearm    = i_edge ? (i_data > w_hi) : (i_data < w_lo);
    o_trig     = w_cond && r_armed;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b1;
    end else if (i_valid) begin
      if (o_trig) begin
        r_armed <= 1'b0;
      end else if (w_rearm) begin
        r_armed <= 1'b1;
      end
    end
  end
`else
  always_comb begin
    o_trig = w_cond;
  end
`endif

endmodule

// File: rtl/capture_write_ctrl.sv
// capture_write_ctrl -- pre/post trigger capture write controller for an
// 8192 x 11 DPRAM (port A).
//   clk, rst_n          : clock, asynchronous active-low reset
//   arm                 : one-cycle pulse, (re)starts a capture
//   pre_depth           : samples kept before the trigger
//   post_depth          : samples kept from the trigger onward
//   trig_level          : unsigned threshold
//   trig_edge           : 0 = rising, 1 = falling
//   force_trig          : software trigger (held pending until next sample)
//   s_valid, s_data     : sample stream
//   trig_hyst           : hysteresis band (only with CAPTURE_TRIG_HYST_EN)
//   ram_addr/wr_data/wr_en : registered RAM write port
//   trig_addr           : RAM address of the trigger sample
//   start_addr          : RAM address of the oldest retained sample
//   busy                : capture in progress
//   done                : capture complete, held until next arm
// Optional feature macro: CAPTURE_TRIG_HYST_EN.
module capture_write_ctrl
  import capture_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arm,
  input  logic [CAP_ADDR_W-1:0] pre_depth,
  input  logic [CAP_CNT_W-1:0]  post_depth,
  input  logic [CAP_DATA_W-1:0] trig_level,
  input  logic                  trig_edge,
  input  logic                  force_trig,
  input  logic                  s_valid,
  input  logic [CAP_DATA_W-1:0] s_data,
`ifdef CAPTURE_TRIG_HYST_EN
  input  logic [4:0]            trig_hyst,
`endif
  output logic [CAP_ADDR_W-1:0] ram_addr,
  output logic [CAP_DATA_W-1:0] ram_wr_data,
  output logic                  ram_wr_en,
  output logic [CAP_ADDR_W-1:0] trig_addr,
  output logic [CAP_ADDR_W-1:0] start_addr,
  output logic                  busy,
  output logic                  done
);

  localparam logic [CAP_CNT_W-1:0]  CNT_ONE = CAP_CNT_W'(1);
  localparam logic [CAP_ADDR_W-1:0] PTR_ONE = CAP_ADDR_W'(1);

  cap_state_e            r_state;
  cap_state_e            w_next;

  logic [CAP_ADDR_W-1:0] r_pre;
  logic [CAP_CNT_W-1:0]  r_post_eff;
  logic [CAP_DATA_W-1:0] r_level;
  logic                  r_edge;
  logic [CAP_ADDR_W-1:0] r_wptr;
  logic [CAP_CNT_W-1:0]  r_cnt;
  logic                  r_force_pend;
  logic                  r_wr_en;
  logic [CAP_ADDR_W-1:0] r_addr;
  logic [CAP_DATA_W-1:0] r_data;
  logic [CAP_ADDR_W-1:0] r_trig_addr;
  logic [CAP_ADDR_W-1:0] r_start_addr;

  logic                  w_active;
  logic                  w_accept;
  logic                  w_wait;
  logic                  w_det_trig;
  logic                  w_fire;

  // The arm cycle itself accepts no sample: the capture begins afresh on the
  // following cycle.
  always_comb begin
    w_active = (r_state == FILL) || (r_state == WAIT_TRIG) || (r_state == POST);
    w_accept = s_valid && !arm && w_active;
    w_wait   = (r_state == WAIT_TRIG);
    w_fire   = w_wait && w_accept && (w_det_trig || force_trig || r_force_pend);
  end

  capture_trig_det u_trig_det (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (arm),
    .i_valid (w_accept),
    .i_eval  (w_wait),
    .i_data  (s_data),
    .i_level (r_level),
    .i_edge  (r_edge),
`ifdef CAPTURE_TRIG_HYST_EN
    .i_hyst  (trig_hyst),
`endif
    .o_trig  (w_det_trig)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: w_next = IDLE;
      FILL: begin
        if (w_accept && ((r_cnt + CNT_ONE) == {1'b0, r_pre})) begin
          w_next = WAIT_TRIG;
        end
      end
      WAIT_TRIG: begin
        if (w_fire) begin
          w_next = (r_post_eff == CNT_ONE) ? DONE : POST;
        end
      end
      POST: begin
        if (w_accept && ((r_cnt + CNT_ONE) == r_post_eff)) begin
          w_next = DONE;
        end
      end
      DONE: w_next = DONE;
      default: w_next = IDLE;
    endcase
    if (arm) begin
      w_next = (pre_depth == '0) ? WAIT_TRIG : FILL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre        <= '0;
      r_post_eff   <= '0;
      r_level      <= '0;
      r_edge       <= 1'b0;
      r_wptr       <= '0;
      r_cnt        <= '0;
      r_force_pend <= 1'b0;
      r_wr_en      <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_trig_addr  <= '0;
      r_start_addr <= '0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_addr <= r_wptr;
        r_data <= s_data;
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (arm) begin
        r_pre        <= pre_depth;
        r_post_eff   <= eff_post_count(pre_depth, post_depth);
        r_level      <= trig_level;
        r_edge       <= trig_edge;
        r_wptr       <= '0;
        r_cnt        <= '0;
        r_force_pend <= 1'b0;
      end else begin
        unique case (r_state)
          FILL: begin
            if (w_accept) begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          WAIT_TRIG: begin
            if (w_fire) begin
              r_trig_addr  <= r_wptr;
              r_start_addr <= r_wptr - r_pre;
              r_cnt        <= CNT_ONE;
              r_force_pend <= 1'b0;
            end else if (force_trig) begin
              r_force_pend <= 1'b1;
            end
          end
          POST: begin
            if (w_accept) begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign ram_addr    = r_addr;
  assign ram_wr_data = r_data;
  assign ram_wr_en   = r_wr_en;
  assign trig_addr   = r_trig_addr;
  assign start_addr  = r_start_addr;
  assign busy        = w_active;
  assign done        = (r_state == DONE);

endmodule

// File: tb/tb_capture_write_ctrl.sv
// Directed bench for capture_write_ctrl. Every sample driven pushes its
// expected RAM write (address, data) to a queue; a negedge monitor pops and
// compares each write the DUT issues and flags any write that was not expected.
module tb_capture_write_ctrl;
  import capture_pkg::*;

  typedef struct packed {
    logic [12:0] a;
    logic [10:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm = 1'b0;
  logic [12:0] pre_depth = '0;
  logic [13:0] post_depth = '0;
  logic [10:0] trig_level = '0;
  logic        trig_edge = 1'b0;
  logic        force_trig = 1'b0;
  logic        s_valid = 1'b0;
  logic [10:0] s_data = '0;
`ifdef CAPTURE_TRIG_HYST_EN
  logic [4:0]  trig_hyst = 5'd10;
`endif
  logic [12:0] ram_addr;
  logic [10:0] ram_wr_data;
  logic        ram_wr_en;
  logic [12:0] trig_addr;
  logic [12:0] start_addr;
  logic        busy;
  logic        done;

  wr_t         q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          n_wr = 0;
  int          base;
  logic [12:0] last_addr = '0;
  logic [12:0] m_ptr = '0;

  always #5 clk = ~clk;

  capture_write_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arm         (arm),
    .pre_depth   (pre_depth),
    .post_depth  (post_depth),
    .trig_level  (trig_level),
    .trig_edge   (trig_edge),
    .force_trig  (force_trig),
    .s_valid     (s_valid),
    .s_data      (s_data),
`ifdef CAPTURE_TRIG_HYST_EN
    .trig_hyst   (trig_hyst),
`endif
    .ram_addr    (ram_addr),
    .ram_wr_data (ram_wr_data),
    .ram_wr_en   (ram_wr_en),
    .trig_addr   (trig_addr),
    .start_addr  (start_addr),
    .busy        (busy),
    .done        (done)
  );

  always @(negedge clk) begin
    wr_t got;
    wr_t exp;
    if (ram_wr_en) begin
      n_wr++;
      last_addr = ram_addr;
      got.a = ram_addr;
      got.d = ram_wr_data;
      vectors++;
      assert (q.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_write: observed addr %0d data %0d, required no write", ram_addr, ram_wr_data);
      end
      if (q.size() != 0) begin
        exp = q.pop_front();
        vectors++;
        assert (got === exp) else begin
          miscompares++;
          $error("FAIL ram_write: observed addr %0d data %0d, required addr %0d data %0d", got.a, got.d, exp.a, exp.d);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // One cycle of stimulus; wr says whether this sample must reach the RAM.
  task automatic cyc(input logic v, input logic [10:0] d, input logic f, input logic wr);
    wr_t e;
    @(posedge clk); #1;
    arm = 1'b0;
    s_valid = v;
    s_data = d;
    force_trig = f;
    if (wr) begin
      e.a = m_ptr;
      e.d = d;
      q.push_back(e);
      m_ptr = m_ptr + 13'd1;
    end
  endtask

  task automatic do_arm(input logic [12:0] pre, input logic [13:0] post,
                        input logic [10:0] lvl, input logic edg);
    @(posedge clk); #1;
    arm = 1'b1;
    s_valid = 1'b0;
    force_trig = 1'b0;
    pre_depth = pre;
    post_depth = post;
    trig_level = lvl;
    trig_edge = edg;
    m_ptr = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 11'd0, 1'b0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"},  32'(ram_addr), 0);
    chk({tag, "_data"},  32'(ram_wr_data), 0);
    chk({tag, "_wren"},  32'(ram_wr_en), 0);
    chk({tag, "_trig"},  32'(trig_addr), 0);
    chk({tag, "_start"}, 32'(start_addr), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
  endtask

  initial begin
    // reset state, then samples in IDLE must not be written
    #12;
    chk_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b1, 11'(123 + i), 1'b0, 1'b0);
    idle(2);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_done", 32'(done), 0);

    // ramp, pre=100 post=200 level=1000 rising
    base = n_wr;
    do_arm(13'd100, 14'd200, 11'd1000, 1'b0);
    idle(1);
    chk("s1_busy_armed", 32'(busy), 1);
    chk("s1_done_armed", 32'(done), 0);
    for (int i = 0; i < 1200; i++) cyc(1'b1, 11'(i), 1'b0, 1'b1);
    for (int i = 1200; i < 1210; i++) cyc(1'b1, 11'(i), 1'b0, 1'b0);
    idle(2);
    chk("s1_trig_addr", 32'(trig_addr), 1000);
    chk("s1_start_addr", 32'(start_addr), 900);
    chk("s1_writes", 32'(n_wr - base), 1200);
    chk("s1_done", 32'(done), 1);
    chk("s1_busy", 32'(busy), 0);

    // falling edge: pattern in FILL ignored, same pattern in WAIT_TRIG fires
    do_arm(13'd2, 14'd3, 11'd500, 1'b1);
    idle(1);
    chk("s2_done_cleared", 32'(done), 0);
    cyc(1'b1, 11'd600, 1'b0, 1'b1);
    cyc(1'b1, 11'd400, 1'b0, 1'b1);
    cyc(1'b1, 11'd600, 1'b0, 1'b1);
    cyc(1'b1, 11'd400, 1'b0, 1'b1);
    cyc(1'b1, 11'd450, 1'b0, 1'b1);
    cyc(1'b1, 11'd300, 1'b0, 1'b1);
    cyc(1'b1, 11'd100, 1'b0, 1'b0);
    idle(2);
    chk("s2_trig_addr", 32'(trig_addr), 3);
    chk("s2_start_addr", 32'(start_addr), 1);
    chk("s2_done", 32'(done), 1);

    // first sample after arm has no predecessor and cannot trigger
    do_arm(13'd0, 14'd2, 11'd500, 1'b0);
    cyc(1'b1, 11'd600, 1'b0, 1'b1);
    cyc(1'b1, 11'd700, 1'b0, 1'b1);
    cyc(1'b1, 11'd100, 1'b0, 1'b1);
    cyc(1'b1, 11'd600, 1'b0, 1'b1);
    cyc(1'b1, 11'd50, 1'b0, 1'b1);
    cyc(1'b1, 11'd60, 1'b0, 1'b0);
    idle(2);
    chk("s3_trig_addr", 32'(trig_addr), 3);
    chk("s3_start_addr", 32'(start_addr), 3);
    chk("s3_done", 32'(done), 1);

    // force_trig with no sample present, post=1
    base = n_wr;
    do_arm(13'd4, 14'd1, 11'd1000, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 11'd50, 1'b0, 1'b1);
    cyc(1'b0, 11'd50, 1'b1, 1'b0);
    cyc(1'b0, 11'd50, 1'b0, 1'b0);
    cyc(1'b0, 11'd50, 1'b0, 1'b0);
    cyc(1'b1, 11'd50, 1'b0, 1'b1);
    cyc(1'b1, 11'd50, 1'b0, 1'b0);
    idle(2);
    chk("s4_trig_addr", 32'(trig_addr), 6);
    chk("s4_start_addr", 32'(start_addr), 2);
    chk("s4_writes", 32'(n_wr - base), 7);
    chk("s4_done", 32'(done), 1);

    // post_depth=0 still keeps the trigger sample
    base = n_wr;
    do_arm(13'd0, 14'd0, 11'd0, 1'b0);
    cyc(1'b1, 11'd77, 1'b1, 1'b1);
    cyc(1'b1, 11'd78, 1'b0, 1'b0);
    idle(2);
    chk("s5_writes", 32'(n_wr - base), 1);
    chk("s5_trig_addr", 32'(trig_addr), 0);
    chk("s5_done", 32'(done), 1);

    // pre=8000 post=1000: post clipped to 192, pointer wraps through 0
    base = n_wr;
    do_arm(13'd8000, 14'd1000, 11'd0, 1'b0);
    for (int i = 0; i < 8100; i++) cyc(1'b1, 11'(i), 1'b0, 1'b1);
    for (int i = 0; i < 192; i++) cyc(1'b1, 11'(i + 5), (i == 0), 1'b1);
    cyc(1'b1, 11'd9, 1'b0, 1'b0);
    idle(2);
    chk("s6_trig_addr", 32'(trig_addr), 8100);
    chk("s6_start_addr", 32'(start_addr), 100);
    chk("s6_last_addr", 32'(last_addr), 99);
    chk("s6_writes", 32'(n_wr - base), 8292);
    chk("s6_done", 32'(done), 1);

    // re-arm during POST restarts at address 0
    do_arm(13'd2, 14'd10, 11'd0, 1'b0);
    cyc(1'b1, 11'd1, 1'b0, 1'b1);
    cyc(1'b1, 11'd2, 1'b0, 1'b1);
    cyc(1'b1, 11'd3, 1'b1, 1'b1);
    cyc(1'b1, 11'd4, 1'b0, 1'b1);
    cyc(1'b1, 11'd5, 1'b0, 1'b1);
    do_arm(13'd1, 14'd1, 11'd0, 1'b0);
    idle(1);
    chk("s7_busy_rearm", 32'(busy), 1);
    chk("s7_done_rearm", 32'(done), 0);
    cyc(1'b1, 11'd900, 1'b0, 1'b1);
    cyc(1'b1, 11'd901, 1'b1, 1'b1);
    idle(2);
    chk("s7_trig_addr", 32'(trig_addr), 1);
    chk("s7_start_addr", 32'(start_addr), 0);
    chk("s7_done", 32'(done), 1);

    // reset during WAIT_TRIG discards the capture
    do_arm(13'd1, 14'd5, 11'd0, 1'b0);
    cyc(1'b1, 11'd10, 1'b0, 1'b1);
    cyc(1'b1, 11'd11, 1'b0, 1'b1);
    idle(2);
    chk("s8_busy_wait", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("s8_rst");
    idle(3);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 11'd5, 1'b0, 1'b0);
    cyc(1'b1, 11'd6, 1'b0, 1'b0);
    idle(2);
    chk("s8_busy_after", 32'(busy), 0);
    chk("s8_trig_after", 32'(trig_addr), 0);
    do_arm(13'd0, 14'd1, 11'd0, 1'b0);
    cyc(1'b1, 11'd33, 1'b1, 1'b1);
    idle(2);
    chk("s8_trig_addr", 32'(trig_addr), 0);
    chk("s8_done", 32'(done), 1);

`ifdef CAPTURE_TRIG_HYST_EN
    // hysteresis 10 around 1000: 1001 after 995 must not re-fire
    do_arm(13'd1, 14'd1, 11'd1000, 1'b0);
    cyc(1'b1, 11'd999, 1'b0, 1'b1);
    cyc(1'b1, 11'd1000, 1'b0, 1'b1);
    idle(2);
    chk("h1_trig_addr", 32'(trig_addr), 1);
    do_arm(13'd0, 14'd3, 11'd1000, 1'b0);
    cyc(1'b1, 11'd995, 1'b0, 1'b1);
    cyc(1'b1, 11'd1001, 1'b0, 1'b1);
    cyc(1'b1, 11'd989, 1'b0, 1'b1);
    cyc(1'b1, 11'd1000, 1'b0, 1'b1);
    cyc(1'b1, 11'd5, 1'b0, 1'b1);
    cyc(1'b1, 11'd6, 1'b0, 1'b1);
    idle(2);
    chk("h2_trig_addr", 32'(trig_addr), 3);
    chk("h2_done", 32'(done), 1);
`endif

    idle(3);
    chk("sb_drained", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/capture_write_ctrl.md
CAPTURE_WRITE_CTRL -- requirements
Module: capture_write_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Port clk, input, 1 bit: sole clock; all state SHALL be rising-edge clocked.
REQ-003 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 Port arm, input, 1 bit: one-cycle pulse that starts a capture.
REQ-005 Port pre_depth, input, 13 bits: number of samples to keep before the trigger.
REQ-006 Port post_depth, input, 14 bits: number of samples to keep from the trigger onward, including the trigger sample.
REQ-007 Port trig_level, input, 11 bits: unsigned trigger threshold.
REQ-008 Port trig_edge, input, 1 bit: 0 selects rising edge, 1 selects falling edge.
REQ-009 Port force_trig, input, 1 bit: software trigger.
REQ-010 Port s_valid, input, 1 bit: sample strobe.
REQ-011 Port s_data, input, 11 bits: unsigned sample.
REQ-012 Port ram_addr, output, 13 bits: write address to the 8192x11 DPRAM port A.
REQ-013 Port ram_wr_data, output, 11 bits: write data to the DPRAM.
REQ-014 Port ram_wr_en, output, 1 bit: write enable to the DPRAM.
REQ-015 Port trig_addr, output, 13 bits: RAM address of the trigger sample.
REQ-016 Port start_addr, output, 13 bits: RAM address of the oldest retained sample.
REQ-017 Port busy, output, 1 bit: capture in progress.
REQ-018 Port done, output, 1 bit: capture complete; sticky.
REQ-019 Port trig_hyst, input, 5 bits: hysteresis band; the port SHALL exist only when CAPTURE_TRIG_HYST_EN is defined.

Function
REQ-020 The state machine SHALL have the states IDLE, FILL, WAIT_TRIG, POST and DONE.
REQ-021 On arm, the block SHALL:
- latch pre_depth, post_depth, trig_level and trig_edge;
- clear the write pointer to 0;
- clear done;
- enter FILL, or WAIT_TRIG directly if pre_depth is 0.
REQ-022 Each s_valid sample accepted in FILL, WAIT_TRIG or POST SHALL be written to the RAM with exactly one cycle of latency: ram_wr_en, ram_addr and ram_wr_data are all registered.
REQ-023 After each write, the write pointer SHALL increment and wrap from 8191 to 0.
REQ-024 FILL SHALL move to WAIT_TRIG once pre_depth samples have been written; no trigger evaluation SHALL take place in FILL.
REQ-025 Rising-edge trigger condition: previous valid sample < level AND current sample >= level. Falling-edge condition: previous sample >= level AND current sample < level.
REQ-026 The first sample after arm SHALL have no predecessor and therefore SHALL never trigger.
REQ-027 In WAIT_TRIG, a trigger condition or force_trig SHALL:
- record the current write address as trig_addr;
- record trig_addr minus pre_depth (mod 8192) as start_addr;
- enter POST.
The trigger sample itself SHALL be written to the RAM. force_trig without s_valid SHALL trigger on the next accepted sample.
REQ-028 POST SHALL end after the effective post count of samples has been written (trigger sample included), then enter DONE with done=1 and busy=0.
REQ-029 Effective post count = max(1, min(post_depth, 8192 - pre_depth)).
REQ-030 busy SHALL be 1 in the FILL, WAIT_TRIG and POST states.
REQ-031 An arm pulse in any non-IDLE state SHALL abort the current capture and restart it at REQ-021 in the same cycle.
REQ-032 Samples arriving in IDLE or DONE SHALL NOT be written.

Reset
REQ-033 While rst_n is low, the block SHALL hold:
- state = IDLE;
- ram_wr_en, busy, done = 0;
- ram_addr, ram_wr_data, trig_addr, start_addr = 0;
- previous-sample register = 0, and the previous-sample valid flag = 0.
REQ-034 Reset asserted mid-capture SHALL discard the capture. No write SHALL occur in the first cycle after reset is released.

Configuration
REQ-035 When CAPTURE_TRIG_HYST_EN is defined, after a rising-edge trigger fires, re-arming SHALL require a sample below level minus trig_hyst (saturating at 0). The falling-edge case SHALL be mirrored, with the band above level and saturating at 2047.
REQ-036 When CAPTURE_TRIG_HYST_EN is undefined, the trig_hyst port and the hysteresis logic SHALL be absent, and behaviour SHALL be exactly as in REQ-025.

Structure
REQ-037 A shared package capture_pkg SHALL hold:
- CAP_ADDR_W = 13;
- CAP_DATA_W = 11;
- CAP_DEPTH = 8192;
- the state enum.
REQ-038 Edge and hysteresis comparison SHALL reside in one sub-module, capture_trig_det, which is purely combinational apart from the previous-sample and re-arm registers.

Verification
REQ-039 Scenario: pre=100, post=200, ramp 0..2047 with level=1000 rising -> trig_addr=1000, start_addr=900, 1200 writes in total, done=1.
REQ-040 Scenario: pre=8000, post=1000 -> effective post count of 192, last write at address (trig_addr+191) mod 8192, pointer wraps through 0.
REQ-041 Scenario: level=500, falling edge, samples 600,400 arriving during FILL -> no trigger; the same pattern in WAIT_TRIG -> trigger on the sample 400.
REQ-042 Scenario: constant input with force_trig pulsed and s_valid low for 3 cycles -> trigger recorded on the next valid sample; post=1 -> exactly one post write.
REQ-043 Scenario: re-arm during POST, and rst_n low during WAIT_TRIG -> restart at address 0 in both cases; reset case leaves all outputs at 0.
REQ-044 Scenario: with CAPTURE_TRIG_HYST_EN, hyst=10, level=1000, sequence 999,1000,995,1001 -> exactly one trigger; 989,1000 -> second trigger is allowed.
